// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// the PC increment and the bubble word written into IF/ID.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register with load / increment / hold controls.
// Load wins over increment; with neither asserted the PC holds.
import if_stage_pkg::*;

module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_d;
  logic [31:0] pc_q;

  // Next PC: redirect target (word aligned), PC+4 wrapping mod 2^32, or hold.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = word_align(load_pc);
    end else if (inc) begin
      pc_d = pc_q + PC_INC;
    end
  end

  // PC storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= word_align(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: BOOT/RUN/HALT control FSM, PC register and the
// IF/ID pipeline register.
//
// Handshake: IFID_Valid marks IFID_Instr/IFID_PCPlus4 as a real fetched
// instruction. There is no ready; Stall is the downstream back-pressure and,
// when it wins the priority, freezes the PC and the whole IF/ID register so
// the offered instruction stays stable until Stall drops.
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        HaltReq,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrData,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [1:0]  dbg_state
);

  if_state_e   state_d, state_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] pcp4_d, pcp4_q;
  logic        valid_d, valid_q;
  logic        pc_load;
  logic        pc_inc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (Clk),
    .rst_n   (Rst),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (RedirectPC),
    .pc      (pc)
  );

  assign pc_plus4 = pc + PC_INC;

  // Next-state and IF/ID update: Redirect > HaltReq > Stall > advance in RUN.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // One settling cycle at RESET_PC; all requests are ignored here.
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
      ST_RUN: begin
        if (Redirect) begin
          // Squash the wrong-path fetch even if the hazard unit is stalling.
          pc_load = 1'b1;
          instr_d = BUBBLE;
          valid_d = 1'b0;
        end else if (HaltReq) begin
          state_d = ST_HALT;
          valid_d = 1'b0;
        end else if (!Stall) begin
          pc_inc  = 1'b1;
          instr_d = InstrData;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        // Absorbing until reset.
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and IF/ID register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_BOOT;
      instr_q <= BUBBLE;
      pcp4_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  assign InstrAddr    = pc;
  assign IFID_Instr   = instr_q;
  assign IFID_PCPlus4 = pcp4_q;
  assign IFID_Valid   = valid_q;
  assign Halted       = (state_q == ST_HALT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: two instances (default RESET_PC and a reset PC
// near the top of the address space) share the control inputs, each has its
// own combinational memory and its own behavioural reference model.
module tb_if_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        redir;
  logic [31:0] redir_pc;
  logic        halt_req;
  bit          mem_mode;

  // ---------------- memory ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a, input bit mode);
    return mode ? (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F : a;
  endfunction

  logic [31:0] a_addr, a_data, a_instr, a_p4;
  logic        a_valid, a_halted;
  logic [1:0]  a_dbg;
  logic [31:0] b_addr, b_data, b_instr, b_p4;
  logic        b_valid, b_halted;
  logic [1:0]  b_dbg;

  always_comb a_data = mem_fn(a_addr, mem_mode);
  always_comb b_data = mem_fn(b_addr, mem_mode);

  if_stage dut_a (
    .Clk(clk), .Rst(rst_n), .Stall(stall), .Redirect(redir),
    .RedirectPC(redir_pc), .HaltReq(halt_req), .InstrAddr(a_addr),
    .InstrData(a_data), .IFID_Instr(a_instr), .IFID_PCPlus4(a_p4),
    .IFID_Valid(a_valid), .Halted(a_halted), .dbg_state(a_dbg)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .Clk(clk), .Rst(rst_n), .Stall(stall), .Redirect(redir),
    .RedirectPC(redir_pc), .HaltReq(halt_req), .InstrAddr(b_addr),
    .InstrData(b_data), .IFID_Instr(b_instr), .IFID_PCPlus4(b_p4),
    .IFID_Valid(b_valid), .Halted(b_halted), .dbg_state(b_dbg)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_pc[2], m_instr[2], m_p4[2];
  bit          m_valid[2], m_boot[2], m_halt[2];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] reset_pc_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic model_cycle(input int i);
    if (!rst_n) begin
      m_pc[i] = reset_pc_of(i); m_boot[i] = 1; m_halt[i] = 0;
      m_instr[i] = 0; m_p4[i] = 0; m_valid[i] = 0;
    end else if (m_boot[i]) begin
      m_boot[i] = 0;
    end else if (m_halt[i]) begin
      m_valid[i] = 0;
    end else if (redir) begin
      m_pc[i] = redir_pc & ~32'd3; m_instr[i] = 0; m_valid[i] = 0;
    end else if (halt_req) begin
      m_halt[i] = 1; m_valid[i] = 0;
    end else if (!stall) begin
      m_instr[i] = mem_fn(m_pc[i], mem_mode);
      m_p4[i] = m_pc[i] + 32'd4;
      m_pc[i] = m_pc[i] + 32'd4;
      m_valid[i] = 1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a addr"},   a_addr,          m_pc[0]);
    check({tag, "/a instr"},  a_instr,         m_instr[0]);
    check({tag, "/a p4"},     a_p4,            m_p4[0]);
    check({tag, "/a valid"},  {31'd0, a_valid},  {31'd0, m_valid[0]});
    check({tag, "/a halted"}, {31'd0, a_halted}, {31'd0, m_halt[0]});
    check({tag, "/b addr"},   b_addr,          m_pc[1]);
    check({tag, "/b instr"},  b_instr,         m_instr[1]);
    check({tag, "/b p4"},     b_p4,            m_p4[1]);
    check({tag, "/b valid"},  {31'd0, b_valid},  {31'd0, m_valid[1]});
    check({tag, "/b halted"}, {31'd0, b_halted}, {31'd0, m_halt[1]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit r, input bit s, input bit rd,
                      input logic [31:0] rpc, input bit h);
    rst_n = r; stall = s; redir = rd; redir_pc = rpc; halt_req = h;
    @(posedge clk);
    model_cycle(0);
    model_cycle(1);
    #1;
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0; stall = 0; redir = 0; redir_pc = 0; halt_req = 0; mem_mode = 0;

    // Reset state
    step("reset0", 0, 0, 0, 0, 0);
    step("reset1", 0, 1, 1, 32'h44, 1);
    check("reset a addr", a_addr, 32'h0);
    check("reset b addr", b_addr, 32'hFFFF_FFF8);

    // BOOT ignores every request
    step("boot", 1, 1, 1, 32'h84, 1);
    check("boot a addr", a_addr, 32'h0);
    check("boot halted", {31'd0, a_halted}, 32'd0);

    // Free run, memory word = address
    step("run1", 1, 0, 0, 0, 0);
    step("run2", 1, 0, 0, 0, 0);
    check("wrap b p4", b_p4, 32'h0000_0000);
    check("wrap b addr", b_addr, 32'h0000_0000);
    step("run3", 1, 0, 0, 0, 0);
    check("run a instr", a_instr, 32'h8);
    check("run a p4", a_p4, 32'hC);
    step("run4", 1, 0, 0, 0, 0);
    check("run a addr", a_addr, 32'h10);

    // Stall three cycles at PC=0x10
    for (int k = 0; k < 3; k++) begin
      step("stall", 1, 1, 0, 0, 0);
      check("stall a addr", a_addr, 32'h10);
      check("stall a instr", a_instr, 32'hC);
    end
    step("resume", 1, 0, 0, 0, 0);
    check("resume a instr", a_instr, 32'h10);

    // Redirect with stall
    step("redir", 1, 1, 1, 32'h0000_0043, 0);
    check("redir a addr", a_addr, 32'h40);
    check("redir a valid", {31'd0, a_valid}, 32'd0);
    step("post_redir", 1, 0, 0, 0, 0);
    check("post_redir a instr", a_instr, 32'h40);

    // Halt at PC=0x20
    step("to20", 1, 0, 1, 32'h22, 0);
    step("halt", 1, 0, 0, 0, 1);
    check("halt a halted", {31'd0, a_halted}, 32'd1);
    check("halt a addr", a_addr, 32'h20);
    step("halt_redir", 1, 0, 1, 32'h80, 0);
    check("halt_redir a addr", a_addr, 32'h20);
    step("halt_stall", 1, 1, 0, 0, 1);
    step("halt_reset", 0, 0, 1, 32'h80, 1);
    check("halt_reset a addr", a_addr, 32'h0);

    // Redirect and HaltReq together
    step("boot2", 1, 0, 0, 0, 0);
    step("redir_halt", 1, 0, 1, 32'h100, 1);
    check("redir_halt a addr", a_addr, 32'h100);
    check("redir_halt halted", {31'd0, a_halted}, 32'd0);
    step("after_rh", 1, 0, 0, 0, 0);
    check("after_rh a instr", a_instr, 32'h100);

    // Reset in the middle of a stall
    step("midstall", 1, 1, 0, 0, 0);
    step("midstall_rst", 0, 1, 0, 0, 0);
    check("midstall_rst a addr", a_addr, 32'h0);

    // Randomized traffic against the model
    mem_mode = 1;
    for (int k = 0; k < 400; k++) begin
      exp_q.push_back(m_pc[0]);
      step("rand",
           ($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0),
           $urandom,
           ($urandom_range(0, 59) == 0));
      void'(exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
